// File: rtl/seq_match_arbiter.sv
// Round-robin shared pattern matcher for several serial bit streams.
// One granted bit per cycle is shifted into its channel history and compared.
module seq_match_arbiter #(
  parameter int N_CH = 4,
  parameter int PAT_W = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [PAT_W-1:0]        cfg_pattern,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH-1:0]         bit_in,
  output logic [N_CH-1:0]         grant,
  output logic                    match_valid,
  output logic [$clog2(N_CH)-1:0] match_ch,
  output logic [7:0]              match_count,
  output logic [PAT_W-1:0]        target
);

  localparam int CW = $clog2(N_CH);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q [N_CH];
  logic [PAT_W-1:0] hist_d [N_CH];
  logic [FW-1:0]    fill_q [N_CH];
  logic [FW-1:0]    fill_d [N_CH];
  logic [CW-1:0]    ptr_q, ptr_d;
  logic [PAT_W-1:0] target_q, target_d;
  logic             match_valid_q, match_valid_d;
  logic [CW-1:0]    match_ch_q, match_ch_d;
  logic [7:0]       match_count_q, match_count_d;

  logic             gnt_any;
  logic [CW-1:0]    gidx;
  logic [CW-1:0]    idx;
  int               sum;
  logic [PAT_W-1:0] cur_hist;
  logic [PAT_W-1:0] new_hist;
  logic [FW-1:0]    cur_fill;
  logic [FW-1:0]    new_fill;
  logic             hit;

  // First requester at or after ptr, wrapping; blocked by reset/config.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gidx    = '0;
    idx     = '0;
    sum     = 0;
    if (!reset && !cfg_we) begin
      for (int k = 0; k < N_CH; k++) begin
        sum = int'(ptr_q) + k;
        if (sum >= N_CH) sum = sum - N_CH;
        idx = CW'(sum);
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gidx    = idx;
        end
      end
    end
    if (gnt_any) grant[gidx] = 1'b1;
  end

  always_comb begin
    cur_hist = hist_q[gidx];
    cur_fill = fill_q[gidx];
    new_hist = {cur_hist[PAT_W-2:0], bit_in[gidx]};
    new_fill = (cur_fill == FULL) ? cur_fill : cur_fill + 1'b1;
    hit      = gnt_any && (new_hist == target_q) && (new_fill == FULL);
  end

  always_comb begin
    hist_d        = hist_q;
    fill_d        = fill_q;
    ptr_d         = ptr_q;
    target_d      = target_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    match_count_d = match_count_q;
    if (cfg_we) begin
      target_d = cfg_pattern;
      for (int i = 0; i < N_CH; i++) begin
        hist_d[i] = '0;
        fill_d[i] = '0;
      end
      ptr_d         = '0;
      match_count_d = '0;
    end else if (gnt_any) begin
      hist_d[gidx] = new_hist;
      fill_d[gidx] = new_fill;
      ptr_d = (gidx == CW'(N_CH - 1)) ? '0 : gidx + 1'b1;
      if (hit) begin
        match_valid_d = 1'b1;
        match_ch_d    = gidx;
        if (match_count_q != 8'hFF)
          match_count_d = match_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
      ptr_q         <= '0;
      target_q      <= DEFAULT_PAT;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      match_count_q <= '0;
    end else begin
      hist_q        <= hist_d;
      fill_q        <= fill_d;
      ptr_q         <= ptr_d;
      target_q      <= target_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      match_count_q <= match_count_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign match_count = match_count_q;
  assign target      = target_q;

endmodule
